// File: rtl/time_field_editor.sv
// time_field_editor: button-driven editor for the alarm clock's set-time buffer
// and alarm registers. It turns raw shift/up/down/OK levels into clean press
// pulses plus auto-repeat ticks, and applies them to the field picked by the
// cursor. An OK press commits the edit: a LOAD_TIME strobe in NOW mode, or
// ARM_VALID in ARM mode.
module time_field_editor #(
   parameter logic [23:0] REPEAT_DLY = 24'd5000000,
   parameter logic [23:0] REPEAT_PER = 24'd1000000
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic [2:0] STATE,
   input  logic       shift,
   input  logic       up,
   input  logic       down,
   input  logic       OK,
   input  logic [6:0] HOUR,
   input  logic [6:0] MIN,
   input  logic [6:0] SEC,
   output logic [6:0] SET_HOUR,
   output logic [6:0] SET_MIN,
   output logic [6:0] SET_SEC,
   output logic [6:0] ARM_HOUR,
   output logic [6:0] ARM_MIN,
   output logic [6:0] ARM_SEC,
   output logic [3:0] shift_now,
   output logic [3:0] shift_arm,
   output logic       LOAD_TIME,
   output logic       ARM_VALID
);

   typedef enum logic [1:0] {
      MODE_NONE = 2'd0,
      MODE_NOW  = 2'd1,
      MODE_ARM  = 2'd2
   } mode_e;

   // Button vector bit positions: 0 up, 1 down, 2 shift, 3 OK.
   localparam int BtnUp    = 0;
   localparam int BtnDown  = 1;
   localparam int BtnShift = 2;
   localparam int BtnOk    = 3;

   mode_e       mode_q, mode_d;
   logic [3:0]  sync1_q, sync2_q, prev_q, pulse_q;
   logic [6:0]  setHour_q, setHour_d, setMin_q, setMin_d, setSec_q, setSec_d;
   logic [6:0]  armHour_q, armHour_d, armMin_q, armMin_d, armSec_q, armSec_d;
   logic [3:0]  cursor_q, cursor_d;
   logic        loadTime_q, loadTime_d;
   logic        armValid_q, armValid_d;
   logic [23:0] upCnt_q, upCnt_d, downCnt_q, downCnt_d;
   logic        upRep_q, upRep_d, downRep_q, downRep_d;

   logic entry;
   logic cursorMoved;
   logic upRun, downRun;
   logic upTick, downTick;
   logic upStep, downStep;

   // One step of a field: out-of-range values snap to 0, in-range values wrap
   // around at 0 and maxV.
   function automatic logic [6:0] stepField(input logic [6:0] v,
                                            input logic [6:0] maxV,
                                            input logic       isUp);
      logic [6:0] r;
      if (v > maxV) begin
         r = 7'd0;
      end else if (isUp) begin
         r = (v == maxV) ? 7'd0 : v + 7'd1;
      end else begin
         r = (v == 7'd0) ? maxV : v - 7'd1;
      end
      return r;
   endfunction

   // Synchronize the raw buttons and register a one-cycle rising-edge pulse.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         sync1_q <= 4'd0;
         sync2_q <= 4'd0;
         prev_q  <= 4'd0;
         pulse_q <= 4'd0;
      end else begin
         sync1_q <= {OK, shift, down, up};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         pulse_q <= sync2_q & ~prev_q;
      end
   end

   // Mode register: remembers the previous STATE so that mode entries can be detected.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         mode_q <= MODE_NONE;
      end else begin
         mode_q <= mode_d;
      end
   end

   // Decode the incoming STATE; any unknown code behaves as NONE.
   always_comb begin
      case (STATE)
         3'd1:    mode_d = MODE_NOW;
         3'd2:    mode_d = MODE_ARM;
         default: mode_d = MODE_NONE;
      endcase
   end

   assign entry       = (mode_d != mode_q);
   assign cursorMoved = (cursor_d != cursor_q);

   assign upRun    = sync2_q[BtnUp] & ~sync2_q[BtnDown] & (cursor_q != 4'd0);
   assign downRun  = sync2_q[BtnDown] & ~sync2_q[BtnUp] & (cursor_q != 4'd0);
   assign upTick   = upRun & (upCnt_q != 24'd0) &
                     (upCnt_q == (upRep_q ? REPEAT_PER : REPEAT_DLY));
   assign downTick = downRun & (downCnt_q != 24'd0) &
                     (downCnt_q == (downRep_q ? REPEAT_PER : REPEAT_DLY));
   assign upStep   = pulse_q[BtnUp] | upTick;
   assign downStep = pulse_q[BtnDown] | downTick;

   // Edit datapath: mode entry first, then OK > shift > up/down within a mode.
   always_comb begin
      setHour_d  = setHour_q;
      setMin_d   = setMin_q;
      setSec_d   = setSec_q;
      armHour_d  = armHour_q;
      armMin_d   = armMin_q;
      armSec_d   = armSec_q;
      cursor_d   = cursor_q;
      armValid_d = armValid_q;
      loadTime_d = 1'b0;
      if (entry) begin
         case (mode_d)
            MODE_NOW: begin
               setHour_d = HOUR;
               setMin_d  = MIN;
               setSec_d  = SEC;
               cursor_d  = 4'd1;
            end
            MODE_ARM: begin
               cursor_d   = 4'd1;
               armValid_d = 1'b0;
            end
            default: begin
               cursor_d = 4'd0;
            end
         endcase
      end else if (mode_q != MODE_NONE) begin
         if (pulse_q[BtnOk]) begin
            if (cursor_q != 4'd0) begin
               if (mode_q == MODE_NOW) begin
                  loadTime_d = 1'b1;
               end else begin
                  armValid_d = 1'b1;
               end
               cursor_d = 4'd0;
            end
         end else if (pulse_q[BtnShift]) begin
            case (cursor_q)
               4'd1:    cursor_d = 4'd2;
               4'd2:    cursor_d = 4'd3;
               default: cursor_d = 4'd1;
            endcase
         end else if ((upStep ^ downStep) && (cursor_q != 4'd0)) begin
            if (mode_q == MODE_NOW) begin
               case (cursor_q)
                  4'd1:    setHour_d = stepField(setHour_q, 7'd23, upStep);
                  4'd2:    setMin_d  = stepField(setMin_q, 7'd59, upStep);
                  4'd3:    setSec_d  = stepField(setSec_q, 7'd59, upStep);
                  default: ;
               endcase
            end else begin
               case (cursor_q)
                  4'd1:    armHour_d = stepField(armHour_q, 7'd23, upStep);
                  4'd2:    armMin_d  = stepField(armMin_q, 7'd59, upStep);
                  4'd3:    armSec_d  = stepField(armSec_q, 7'd59, upStep);
                  default: ;
               endcase
               armValid_d = 1'b0;
            end
         end
      end
   end

   // Auto-repeat counters: start on the press pulse, tick after the initial
   // delay and then periodically; any release, cursor move or mode change restarts them.
   always_comb begin
      upCnt_d   = upCnt_q;
      upRep_d   = upRep_q;
      downCnt_d = downCnt_q;
      downRep_d = downRep_q;
      if (!upRun || entry || cursorMoved) begin
         upCnt_d = 24'd0;
         upRep_d = 1'b0;
      end else if (pulse_q[BtnUp]) begin
         upCnt_d = 24'd1;
         upRep_d = 1'b0;
      end else if (upTick) begin
         upCnt_d = 24'd1;
         upRep_d = 1'b1;
      end else if (upCnt_q != 24'd0) begin
         upCnt_d = upCnt_q + 24'd1;
      end
      if (!downRun || entry || cursorMoved) begin
         downCnt_d = 24'd0;
         downRep_d = 1'b0;
      end else if (pulse_q[BtnDown]) begin
         downCnt_d = 24'd1;
         downRep_d = 1'b0;
      end else if (downTick) begin
         downCnt_d = 24'd1;
         downRep_d = 1'b1;
      end else if (downCnt_q != 24'd0) begin
         downCnt_d = downCnt_q + 24'd1;
      end
   end

   // Register the edit buffers, cursor, strobes and repeat counters.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         setHour_q  <= 7'd0;
         setMin_q   <= 7'd0;
         setSec_q   <= 7'd0;
         armHour_q  <= 7'd0;
         armMin_q   <= 7'd0;
         armSec_q   <= 7'd0;
         cursor_q   <= 4'd0;
         loadTime_q <= 1'b0;
         armValid_q <= 1'b0;
         upCnt_q    <= 24'd0;
         upRep_q    <= 1'b0;
         downCnt_q  <= 24'd0;
         downRep_q  <= 1'b0;
      end else begin
         setHour_q  <= setHour_d;
         setMin_q   <= setMin_d;
         setSec_q   <= setSec_d;
         armHour_q  <= armHour_d;
         armMin_q   <= armMin_d;
         armSec_q   <= armSec_d;
         cursor_q   <= cursor_d;
         loadTime_q <= loadTime_d;
         armValid_q <= armValid_d;
         upCnt_q    <= upCnt_d;
         upRep_q    <= upRep_d;
         downCnt_q  <= downCnt_d;
         downRep_q  <= downRep_d;
      end
   end

   assign SET_HOUR  = setHour_q;
   assign SET_MIN   = setMin_q;
   assign SET_SEC   = setSec_q;
   assign ARM_HOUR  = armHour_q;
   assign ARM_MIN   = armMin_q;
   assign ARM_SEC   = armSec_q;
   assign shift_now = cursor_q;
   assign shift_arm = (mode_q == MODE_ARM) ? cursor_q : 4'd0;
   assign LOAD_TIME = loadTime_q;
   assign ARM_VALID = armValid_q;

endmodule

// File: doc/time_field_editor.md
Name: time_field_editor

Overview:
- Upstream editing stage for the alarm-clock display/mode block.
- Turns the raw shift/up/down/OK button levels into edits of two value sets, gated by the current mode STATE:
  - a "set-time" buffer, SET_HOUR/MIN/SEC;
  - the alarm registers, ARM_HOUR/MIN/SEC.
- Drives the field cursor shift_now, which the display stage blinks.
- On OK, commits the buffer: a one-cycle LOAD_TIME strobe to the timekeeper, or ARM_VALID to the alarm comparator.

Parameters:
- REPEAT_DLY, 24'd5000000, cycles a held up/down must stay high before auto-repeat starts.
- REPEAT_PER, 24'd1000000, cycles between auto-repeat steps once repeating.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESETN  in  1  reset, synchronous, active-low.
- STATE  in  3  mode from the display stage: 0 NONE, 1 NOW (set time), 2 ARM (set alarm); other values are treated as NONE.
- shift, up, down, OK  in  1 each  raw active-high button levels, asynchronous.
- HOUR, MIN, SEC  in  7 each  running time, binary.
- SET_HOUR, SET_MIN, SET_SEC  out  7 each  set-time edit buffer.
- ARM_HOUR, ARM_MIN, ARM_SEC  out  7 each  alarm registers.
- shift_now  out  4  field cursor: 0 none, 1 hour, 2 min, 3 sec.
- shift_arm  out  4  equals shift_now while STATE==ARM, else 0.
- LOAD_TIME  out  1  one-cycle strobe; SET_* valid in the same cycle.
- ARM_VALID  out  1  alarm armed flag.

Behaviour:
- Reset (RESETN low at a posedge):
  - All outputs go to 0.
  - Synchronizer and previous-sample flops go to 0.
  - Repeat counters clear.
  - STATE is registered internally as NONE.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then rising-edge detection, giving a one-cycle press pulse.
  - A raw rise is first sampled at edge n; the pulse is active in cycle n+2; the register update is visible after edge n+3.
  - A button held through reset release produces one press pulse.
- Mode entry (STATE differs from the registered previous STATE):
  - Entering NOW: SET_* <= HOUR/MIN/SEC and shift_now <= 1.
  - Entering ARM: shift_now <= 1; ARM_* keep their values; ARM_VALID <= 0.
  - Entering NONE: shift_now <= 0; SET_* and ARM_* hold.
  - While any entry action occurs, button pulses in that cycle are ignored.
- Editing happens only when STATE is NOW or ARM. Per-cycle priority is OK > shift > up/down.
- OK pulse:
  - In NOW with shift_now != 0: LOAD_TIME = 1 for exactly one cycle, then shift_now <= 0.
  - In ARM with shift_now != 0: ARM_VALID <= 1, then shift_now <= 0.
  - With shift_now == 0: no effect.
- shift pulse:
  - Cursor steps 1 -> 2 -> 3 -> 1.
  - From 0 it goes to 1, re-opening editing without reloading SET_*.
- up/down step (press pulse or repeat tick), with shift_now != 0:
  - The target is SET_* in NOW, ARM_* in ARM.
  - Hour increments mod 24: 23 -> 0 on up, 0 -> 23 on down.
  - Min and sec increment mod 60: 59 -> 0 on up, 0 -> 59 on down.
  - Only the field selected by the cursor changes.
  - up and down stepping in the same cycle: no change.
  - Any step in ARM clears ARM_VALID until the next OK.
- Auto-repeat (one counter per direction):
  - Runs while that synchronized level is high, the other direction is low, and shift_now != 0.
  - The first repeat tick comes REPEAT_DLY cycles after the press pulse; further ticks follow every REPEAT_PER cycles.
  - The counter clears on release, on a cursor change, or on any mode change.
- Leaving NOW without OK discards the edits: no LOAD_TIME, and SET_* is reloaded on the next NOW entry.
- RESETN low mid-edit aborts editing: no LOAD_TIME is issued and all outputs go to reset values.
- Values never exceed 23 (hour) or 59 (min/sec) from editing. Out-of-range HOUR/MIN/SEC inputs are copied as-is, and the next step wraps them to 0.

Test Plan:
- Hour wrap: reset; STATE=1 with HOUR=23, MIN=59, SEC=58 -> SET_*=23/59/58 and shift_now=1; one up press -> SET_HOUR=0; one down press -> 23.
- Cursor and minute edit: shift pressed 3 times -> shift_now 2,3,1; at shift_now=2 with SET_MIN=0, down -> 59, up -> 0, SET_HOUR/SEC unchanged.
- Commit: after edits, press OK -> LOAD_TIME high for exactly 1 cycle with SET_*=edited values, then shift_now=0; later up presses change nothing.
- Alarm: STATE 1->2 -> shift_now=1, shift_arm=1, ARM_VALID=0; set ARM to 07:30:00, press OK -> ARM_VALID=1; one further up -> ARM_VALID=0.
- Auto-repeat (REPEAT_DLY=8, REPEAT_PER=4): hold up for 20 cycles after the pulse at shift_now=3 from SEC=57 -> steps at +0, +8, +12, +16, +20 -> SET_SEC 58, 59, 0, 1, 2; up and down held together -> no steps.
- Abort and priority: OK and up in the same pulse cycle -> commit only, value unchanged; STATE 1->0 mid-edit -> no LOAD_TIME, shift_now=0; RESETN low mid-edit -> all outputs 0 on the next edge.
